tribus_arbiter: RTL

TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

---
 rtl/tribus_pkg.sv | 14 +
 rtl/tribus_if.sv | 24 ++
 rtl/rr_pick.sv | 25 ++
 rtl/tribus_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
package tribus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tribus_if.sv
// Request/grant bundle between requesters and the tri-state bus arbiter.
interface tribus_if #(
  parameter int N = 4
);
  import tribus_pkg::*;

  localparam int IW = clog2w(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  oe;
  logic [IW-1:0] gnt_id;
  logic          busy;

  modport master (
    input  req,
    output gnt, oe, gnt_id, busy
  );

  modport slave (
    output req,
    input  gnt, oe, gnt_id, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
module rr_pick
  import tribus_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_req && req[(int'(ptr) + i) % N]) begin
        any_req = 1'b1;
        winner  = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with hold limit.
module tribus_arbiter
  import tribus_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAXHOLD = 8
) (
  input  logic     clk,
  input  logic     rst,
  tribus_if.master bus
);

  localparam int IW = clog2w(N);
  localparam int CW = clog2w(MAXHOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAXHOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(N - 1);

  state_t        state, nstate;
  logic [IW-1:0] owner, n_owner;
  logic [IW-1:0] ptr, n_ptr;
  logic [IW-1:0] win;
  logic [CW-1:0] cnt, n_cnt;
  logic [N-1:0]  own_mask;
  logic [N-1:0]  n_gnt;
  logic [IW-1:0] n_id;
  logic          any_req;
  logic          others;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (win),
    .any_req (any_req)
  );

  assign own_mask = N'(1) << owner;
  assign others   = |(bus.req & ~own_mask);

  always_comb begin
    nstate  = state;
    n_owner = owner;
    n_ptr   = ptr;
    n_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          nstate  = GRANT;
          n_owner = win;
          n_ptr   = (win == LAST_ID) ? '0 : win + 1'b1;
          n_cnt   = '0;
        end
      end
      GRANT: begin
        // a saturated owner still yields once someone else shows up
        if (!bus.req[owner] || (cnt >= HOLD_LAST && others))
          nstate = TURN;
        else if (cnt != HOLD_MAX)
          n_cnt = cnt + 1'b1;
      end
      TURN: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
    n_gnt = (nstate == GRANT) ? (N'(1) << n_owner) : '0;
    n_id  = (nstate == GRANT) ? n_owner : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      bus.gnt    <= '0;
      bus.oe     <= '0;
      bus.gnt_id <= '0;
      bus.busy   <= 1'b0;
    end else begin
      state      <= nstate;
      owner      <= n_owner;
      ptr        <= n_ptr;
      cnt        <= n_cnt;
      bus.gnt    <= n_gnt;
      bus.oe     <= n_gnt;
      bus.gnt_id <= n_id;
      bus.busy   <= (nstate == GRANT);
    end
  end

endmodule
